// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//
// Read-channel arbiter between the instruction-fetch and data-load
// SRAM-like requesters and the single AXI read port of the core. One
// requester is granted per cycle into a registered AR slot. A bounded
// counter per requester tracks its outstanding reads. R beats are routed
// back by rid, and error responses are flagged. Write channels are not
// handled here.
//
// Configuration macro:
//   AXI_RD_ARB_RR_EN  defined   : round-robin on ties (inst wins the first
//                                 tie after reset)
//                     undefined : fixed priority, data over inst
//
// Parameters:
//   MAX_OUTS  maximum outstanding reads per requester (1..15)
//   INST_ID   arid used for instruction fetches
//   DATA_ID   arid used for data loads
//
// Ports:
//   aclk, aresetn                   clock, asynchronous active-low reset
//   inst_rd_req/addr/size           instruction read request (level-held)
//   inst_rd_addr_ok                 request accepted this cycle (comb)
//   inst_rd_data_ok/rdata           read data return (comb from R)
//   data_rd_*                       same set for data loads
//   arid/araddr/arsize/arvalid      registered AR slot
//   arlen/arburst                   constant single-beat INCR
//   arready                         AR ready from the interconnect
//   rid/rdata/rresp/rlast/rvalid    R channel inputs
//   rready                          R ready, constant 1 once out of reset
//   resp_err                        pulse on any R beat with rresp != 0
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The AR payload holds steady while arvalid=1 and arready=0.
// The requester side treats addr_ok as its ready, and req is held until
// addr_ok.
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int         MAX_OUTS = 2,
    parameter logic [3:0] INST_ID  = 4'd0,
    parameter logic [3:0] DATA_ID  = 4'd1
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        inst_rd_req,
    input  logic [31:0] inst_rd_addr,
    input  logic [1:0]  inst_rd_size,
    output logic        inst_rd_addr_ok,
    output logic        inst_rd_data_ok,
    output logic [31:0] inst_rd_rdata,

    input  logic        data_rd_req,
    input  logic [31:0] data_rd_addr,
    input  logic [1:0]  data_rd_size,
    output logic        data_rd_addr_ok,
    output logic        data_rd_data_ok,
    output logic [31:0] data_rd_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic        resp_err
);

    localparam logic [3:0] LP_MAX = 4'(MAX_OUTS);

    // AR slot
    logic        r_arvalid;
    logic [3:0]  r_arid;
    logic [31:0] r_araddr;
    logic [2:0]  r_arsize;
    logic        r_rready;

    // Outstanding read counters
    logic [3:0]  r_inst_cnt;
    logic [3:0]  r_data_cnt;

    logic        w_slot_free;
    logic        w_inst_elig;
    logic        w_data_elig;
    logic        w_grant_any;
    logic        w_pick_data;
    logic        w_grant_inst;
    logic        w_grant_data;
    logic        w_r_done;
    logic        w_inst_dec;
    logic        w_data_dec;

    // Saturating up/down step. A simultaneous increment and decrement cancel.
    function automatic logic [3:0] cnt_next(input logic [3:0] cnt,
                                            input logic       inc,
                                            input logic       dec);
        logic [3:0] nxt;
        nxt = cnt;
        if (inc && !dec && (cnt < LP_MAX)) begin
            nxt = cnt + 4'd1;
        end else if (dec && !inc && (cnt != 4'd0)) begin
            nxt = cnt - 4'd1;
        end
        return nxt;
    endfunction

    assign w_slot_free = !r_arvalid || arready;
    assign w_inst_elig = inst_rd_req && (r_inst_cnt < LP_MAX);
    assign w_data_elig = data_rd_req && (r_data_cnt < LP_MAX);
    assign w_grant_any = aresetn && w_slot_free && (w_inst_elig || w_data_elig);

`ifdef AXI_RD_ARB_RR_EN
    // 0 = inst, 1 = data. Resetting to data makes inst win the first tie.
    logic r_last_grant;

    // On a tie, grant whichever requester did not win last time.
    assign w_pick_data = w_data_elig && (!w_inst_elig || !r_last_grant);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_last_grant <= 1'b1;
        end else if (w_grant_any) begin
            r_last_grant <= w_pick_data;
        end
    end
`else
    assign w_pick_data = w_data_elig;
`endif

    assign w_grant_inst = w_grant_any && !w_pick_data;
    assign w_grant_data = w_grant_any &&  w_pick_data;

    // Only the last beat of a read retires it. Beats with an unknown rid
    // match neither requester and are dropped.
    assign w_r_done   = rvalid && r_rready && rlast;
    assign w_inst_dec = w_r_done && (rid == INST_ID);
    assign w_data_dec = w_r_done && (rid == DATA_ID);

    // A new grant may reload the slot in the same cycle the old AR leaves,
    // which sustains one AR per cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_arvalid <= 1'b0;
            r_arid    <= 4'd0;
            r_araddr  <= 32'd0;
            r_arsize  <= 3'd0;
        end else if (w_grant_inst) begin
            r_arvalid <= 1'b1;
            r_arid    <= INST_ID;
            r_araddr  <= inst_rd_addr;
            r_arsize  <= {1'b0, inst_rd_size};
        end else if (w_grant_data) begin
            r_arvalid <= 1'b1;
            r_arid    <= DATA_ID;
            r_araddr  <= data_rd_addr;
            r_arsize  <= {1'b0, data_rd_size};
        end else if (arready) begin
            r_arvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rready   <= 1'b0;
            r_inst_cnt <= 4'd0;
            r_data_cnt <= 4'd0;
        end else begin
            r_rready   <= 1'b1;
            r_inst_cnt <= cnt_next(r_inst_cnt, w_grant_inst, w_inst_dec);
            r_data_cnt <= cnt_next(r_data_cnt, w_grant_data, w_data_dec);
        end
    end

    assign inst_rd_addr_ok = w_grant_inst;
    assign data_rd_addr_ok = w_grant_data;

    assign inst_rd_data_ok = aresetn && rvalid && (rid == INST_ID);
    assign data_rd_data_ok = aresetn && rvalid && (rid == DATA_ID);
    assign inst_rd_rdata   = rdata;
    assign data_rd_rdata   = rdata;

    assign resp_err = aresetn && rvalid && (rresp != 2'b00);

    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arsize  = r_arsize;
    assign arvalid = r_arvalid;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign rready  = r_rready;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;

`ifdef AXI_RD_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        aclk;
    logic        aresetn;
    logic        inst_rd_req;
    logic [31:0] inst_rd_addr;
    logic [1:0]  inst_rd_size;
    logic        inst_rd_addr_ok;
    logic        inst_rd_data_ok;
    logic [31:0] inst_rd_rdata;
    logic        data_rd_req;
    logic [31:0] data_rd_addr;
    logic [1:0]  data_rd_size;
    logic        data_rd_addr_ok;
    logic        data_rd_data_ok;
    logic [31:0] data_rd_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        resp_err;

    int n_cmp;
    int n_fail;
    logic [3:0] exp_q[$];

    axi_rd_arbiter dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .inst_rd_req     (inst_rd_req),
        .inst_rd_addr    (inst_rd_addr),
        .inst_rd_size    (inst_rd_size),
        .inst_rd_addr_ok (inst_rd_addr_ok),
        .inst_rd_data_ok (inst_rd_data_ok),
        .inst_rd_rdata   (inst_rd_rdata),
        .data_rd_req     (data_rd_req),
        .data_rd_addr    (data_rd_addr),
        .data_rd_size    (data_rd_size),
        .data_rd_addr_ok (data_rd_addr_ok),
        .data_rd_data_ok (data_rd_data_ok),
        .data_rd_rdata   (data_rd_rdata),
        .arid            (arid),
        .araddr          (araddr),
        .arlen           (arlen),
        .arsize          (arsize),
        .arburst         (arburst),
        .arvalid         (arvalid),
        .arready         (arready),
        .rid             (rid),
        .rdata           (rdata),
        .rresp           (rresp),
        .rlast           (rlast),
        .rvalid          (rvalid),
        .rready          (rready),
        .resp_err        (resp_err)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        inst_req;
        logic [31:0] inst_addr;
        logic        data_req;
        logic [31:0] data_addr;
        logic        ar_rdy;
        logic        r_vld;
        logic [3:0]  r_id;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
        logic        r_last;
        logic        ex_inst_aok;
        logic        ex_data_aok;
        logic        ex_inst_dok;
        logic        ex_data_dok;
        logic        ex_err;
        logic        ex_arvalid;
        logic [3:0]  ex_arid;
        logic [31:0] ex_araddr;
    } vec_t;

    vec_t vecs[10];

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_rd_req  = 1'b0;
        inst_rd_addr = 32'd0;
        inst_rd_size = 2'd2;
        data_rd_req  = 1'b0;
        data_rd_addr = 32'd0;
        data_rd_size = 2'd2;
        arready      = 1'b0;
        rvalid       = 1'b0;
        rid          = 4'd0;
        rdata        = 32'd0;
        rresp        = 2'b00;
        rlast        = 1'b0;
    endtask

    // Leaves the bench one time unit after a rising edge, out of reset.
    task automatic do_reset();
        idle_inputs();
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        inst_rd_req  = v.inst_req;
        inst_rd_addr = v.inst_addr;
        data_rd_req  = v.data_req;
        data_rd_addr = v.data_addr;
        arready      = v.ar_rdy;
        rvalid       = v.r_vld;
        rid          = v.r_id;
        rdata        = v.r_data;
        rresp        = v.r_resp;
        rlast        = v.r_last;
        @(negedge aclk);
        chk($sformatf("v%0d_inst_addr_ok", idx), inst_rd_addr_ok, v.ex_inst_aok);
        chk($sformatf("v%0d_data_addr_ok", idx), data_rd_addr_ok, v.ex_data_aok);
        chk($sformatf("v%0d_inst_data_ok", idx), inst_rd_data_ok, v.ex_inst_dok);
        chk($sformatf("v%0d_data_data_ok", idx), data_rd_data_ok, v.ex_data_dok);
        chk($sformatf("v%0d_resp_err", idx), resp_err, v.ex_err);
        chk($sformatf("v%0d_inst_rdata", idx), inst_rd_rdata, v.r_data);
        chk($sformatf("v%0d_data_rdata", idx), data_rd_rdata, v.r_data);
        next_cycle();
        chk($sformatf("v%0d_arvalid", idx), arvalid, v.ex_arvalid);
        chk($sformatf("v%0d_arid", idx), arid, v.ex_arid);
        chk($sformatf("v%0d_araddr", idx), araddr, v.ex_araddr);
    endtask

    // ---------------- test ----------------
    initial begin
        int         n_pulses;
        logic [3:0] e;
        logic [3:0] prev_id;
        logic       have_prev;

        n_cmp  = 0;
        n_fail = 0;

        //      ireq iaddr         dreq daddr     ardy rv rid   rdata          rresp rlast  iaok daok idok ddok err  arv arid  araddr
        vecs[0] = '{0, 32'h0,        0, 32'h0,   0,   1, 4'd1, 32'hDEADBEEF, 2'b10, 0,   0, 0, 0, 1, 1,   0, 4'd0, 32'h0};
        vecs[1] = '{0, 32'h0,        0, 32'h0,   0,   1, 4'd0, 32'h12345678, 2'b00, 0,   0, 0, 1, 0, 0,   0, 4'd0, 32'h0};
        vecs[2] = '{0, 32'h0,        0, 32'h0,   0,   1, 4'd5, 32'hCAFEF00D, 2'b00, 1,   0, 0, 0, 0, 0,   0, 4'd0, 32'h0};
        vecs[3] = '{0, 32'h0,        0, 32'h0,   0,   1, 4'd5, 32'h0BADF00D, 2'b11, 0,   0, 0, 0, 0, 1,   0, 4'd0, 32'h0};
        vecs[4] = '{0, 32'h0,        0, 32'h0,   0,   0, 4'd1, 32'h55AA55AA, 2'b10, 0,   0, 0, 0, 0, 0,   0, 4'd0, 32'h0};
        vecs[5] = '{1, 32'h1c000000, 0, 32'h0,   1,   0, 4'd0, 32'h0,        2'b00, 0,   1, 0, 0, 0, 0,   1, 4'd0, 32'h1c000000};
        vecs[6] = '{0, 32'h0,        1, 32'h800, 1,   0, 4'd0, 32'h0,        2'b00, 0,   0, 1, 0, 0, 0,   1, 4'd1, 32'h800};
        vecs[7] = '{0, 32'h0,        0, 32'h0,   1,   0, 4'd0, 32'h0,        2'b00, 0,   0, 0, 0, 0, 0,   0, 4'd1, 32'h800};
        vecs[8] = '{0, 32'h0,        0, 32'h0,   1,   1, 4'd0, 32'hA5A5A5A5, 2'b00, 1,   0, 0, 1, 0, 0,   0, 4'd1, 32'h800};
        vecs[9] = '{0, 32'h0,        0, 32'h0,   1,   1, 4'd1, 32'h5A5A5A5A, 2'b01, 1,   0, 0, 0, 1, 1,   0, 4'd1, 32'h800};

        // ---- reset state, with activity on the inputs ----
        idle_inputs();
        aresetn     = 1'b0;
        inst_rd_req = 1'b1;
        data_rd_req = 1'b1;
        arready     = 1'b1;
        rvalid      = 1'b1;
        rid         = 4'd1;
        rresp       = 2'b10;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_inst_addr_ok", inst_rd_addr_ok, 0);
        chk("rst_data_addr_ok", data_rd_addr_ok, 0);
        chk("rst_data_data_ok", data_rd_data_ok, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_arid", arid, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arsize", arsize, 0);
        chk("rst_rready", rready, 0);
        chk("const_arlen", arlen, 0);
        chk("const_arburst", arburst, 2'b01);
        do_reset();
        next_cycle();
        chk("rready_after_reset", rready, 1);

        // ---- table-driven vectors ----
        for (int i = 0; i < 10; i++) begin
            apply_vec(vecs[i], i);
        end

        // ---- reset in the middle of a pending AR ----
        do_reset();
        inst_rd_req  = 1'b1;
        inst_rd_addr = 32'h1c000000;
        arready      = 1'b0;
        @(negedge aclk);
        chk("midrst_grant", inst_rd_addr_ok, 1);
        next_cycle();
        chk("midrst_arvalid_set", arvalid, 1);
        chk("midrst_araddr_set", araddr, 32'h1c000000);
        chk("midrst_arsize_set", arsize, 3'd2);
        inst_rd_req = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        chk("midrst_arvalid_async", arvalid, 0);
        chk("midrst_araddr_async", araddr, 0);
        next_cycle();
        aresetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            chk("midrst_arvalid_stays0", arvalid, 0);
            next_cycle();
        end

        // ---- outstanding limit ----
        do_reset();
        inst_rd_req  = 1'b1;
        inst_rd_addr = 32'h2000;
        arready      = 1'b1;
        n_pulses     = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            if (inst_rd_addr_ok) n_pulses++;
            next_cycle();
        end
        chk("outs_limit_pulses", n_pulses, 2);
        rvalid = 1'b1;
        rid    = 4'd0;
        rlast  = 1'b1;
        @(negedge aclk);
        chk("outs_no_grant_in_ret_cycle", inst_rd_addr_ok, 0);
        next_cycle();
        rvalid = 1'b0;
        @(negedge aclk);
        chk("outs_grant_after_ret", inst_rd_addr_ok, 1);
        next_cycle();
        // Beat with an unknown rid must not free a slot.
        rvalid = 1'b1;
        rid    = 4'd5;
        @(negedge aclk);
        chk("rid5_inst_data_ok", inst_rd_data_ok, 0);
        chk("rid5_data_data_ok", data_rd_data_ok, 0);
        next_cycle();
        rvalid = 1'b0;
        @(negedge aclk);
        chk("rid5_cnt_unchanged", inst_rd_addr_ok, 0);
        next_cycle();
        // Retiring a data read with none outstanding must not underflow.
        rvalid = 1'b1;
        rid    = 4'd1;
        next_cycle();
        rvalid       = 1'b0;
        rlast        = 1'b0;
        data_rd_req  = 1'b1;
        data_rd_addr = 32'h40;
        @(negedge aclk);
        chk("data_cnt_no_underflow", data_rd_addr_ok, 1);
        next_cycle();

        // ---- AR stall holds the payload ----
        do_reset();
        arready      = 1'b0;
        data_rd_req  = 1'b1;
        data_rd_addr = 32'h800;
        data_rd_size = 2'd2;
        @(negedge aclk);
        chk("stall_data_grant", data_rd_addr_ok, 1);
        chk("stall_inst_nogrant", inst_rd_addr_ok, 0);
        next_cycle();
        inst_rd_req  = 1'b1;
        inst_rd_addr = 32'h1000;
        data_rd_addr = 32'h900;
        data_rd_size = 2'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("stall_inst_addr_ok", inst_rd_addr_ok, 0);
            chk("stall_data_addr_ok", data_rd_addr_ok, 0);
            chk("stall_arvalid", arvalid, 1);
            chk("stall_araddr", araddr, 32'h800);
            chk("stall_arsize", arsize, 3'd2);
            chk("stall_arid", arid, 4'd1);
            next_cycle();
        end
        arready = 1'b1;
        @(negedge aclk);
        chk("unstall_inst_addr_ok", inst_rd_addr_ok, RR_EN ? 1 : 0);
        chk("unstall_data_addr_ok", data_rd_addr_ok, RR_EN ? 0 : 1);
        next_cycle();
        chk("unstall_araddr", araddr, RR_EN ? 32'h1000 : 32'h900);

        // ---- tie arbitration, back-to-back ARs ----
        do_reset();
        arready      = 1'b1;
        inst_rd_req  = 1'b1;
        inst_rd_addr = 32'h100;
        data_rd_req  = 1'b1;
        data_rd_addr = 32'h200;
        if (RR_EN) exp_q = '{4'd0, 4'd1, 4'd0, 4'd1};
        else       exp_q = '{4'd1, 4'd1, 4'd1, 4'd0};
        have_prev = 1'b0;
        prev_id   = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (!RR_EN && i == 3) data_rd_req = 1'b0;
            // Retire the previous grant so the limit never gates the tie.
            rvalid = have_prev;
            rid    = prev_id;
            rlast  = 1'b1;
            e = exp_q.pop_front();
            @(negedge aclk);
            chk($sformatf("tie%0d_inst_addr_ok", i), inst_rd_addr_ok, (e == 4'd0));
            chk($sformatf("tie%0d_data_addr_ok", i), data_rd_addr_ok, (e == 4'd1));
            next_cycle();
            chk($sformatf("tie%0d_arvalid", i), arvalid, 1);
            chk($sformatf("tie%0d_arid", i), arid, e);
            chk($sformatf("tie%0d_araddr", i), araddr, (e == 4'd0) ? 32'h100 : 32'h200);
            prev_id   = e;
            have_prev = 1'b1;
        end
        idle_inputs();
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Read-channel arbiter and scheduler between the instruction-fetch and data-load SRAM-like requesters and the single AXI read port of the core. It grants one requester per cycle onto a registered AR slot and tracks outstanding reads per requester with a bounded counter. It routes R beats back by `rid` and flags error responses. It sits between the IF/EX stages and the AXI master port, taking over read scheduling from the bridge; the write channels are not handled here.

## Interface
- `MAX_OUTS`, default 2: maximum outstanding reads per requester, range 1..15.
- `INST_ID`, default 4'd0: `arid` value used for instruction fetches.
- `DATA_ID`, default 4'd1: `arid` value used for data loads.

Ports:
- `aclk` in 1: clock; all state updates on its rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `inst_rd_req` in 1: instruction read request, level-held until `inst_rd_addr_ok`.
- `inst_rd_addr` in 32: instruction read byte address.
- `inst_rd_size` in 2: instruction read size, log2 bytes.
- `inst_rd_addr_ok` out 1: request accepted this cycle.
- `inst_rd_data_ok` out 1: read data valid this cycle.
- `inst_rd_rdata` out 32: instruction read data.
- `data_rd_req`, `data_rd_addr`, `data_rd_size`, `data_rd_addr_ok`, `data_rd_data_ok`, `data_rd_rdata`: same set for data loads.
- `arid` out 4, `araddr` out 32, `arsize` out 3: AR payload, registered.
- `arlen` out 8: constant 0.
- `arburst` out 2: constant 2'b01.
- `arvalid` out 1: AR valid.
- `arready` in 1: AR ready.
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1: R channel inputs.
- `rready` out 1: R ready.
- `resp_err` out 1: one-cycle pulse on any R beat whose `rresp` is non-zero.

## Operation
- AR slot is free when `!arvalid || arready`.
- A requester is eligible when `req && outs_cnt < MAX_OUTS`.
- Grant happens when the slot is free, at least one requester is eligible, and `aresetn` is high. Only the granted requester sees `addr_ok=1` in that cycle.
- On grant, the slot loads `arid`, `araddr`, and `arsize={1'b0,size}`, and sets `arvalid=1`.
- `arvalid` clears on `arvalid&&arready` unless a new grant loads the slot in the same cycle.
- Outstanding counters, one per requester, are 4 bits wide:
  - increment on that requester's grant;
  - decrement on `rvalid&&rready&&rlast&&rid==<ID>`;
  - stay unchanged when both happen in the same cycle;
  - never exceed `MAX_OUTS` and never drop below 0.
- `rready` is constant 1 once out of reset. No backpressure is applied to R.
- `inst_rd_data_ok = rvalid && rid==INST_ID`; `data_rd_data_ok = rvalid && rid==DATA_ID`. Both `rd_rdata` outputs pass `rdata` through combinationally.
- An R beat with any other `rid` is consumed and dropped. Neither `data_ok` asserts and neither counter changes.
- `resp_err = rvalid && rresp!=2'b00`, independent of `rid`.
- Arbitration state `last_grant` is 1 bit: 0 = inst, 1 = data. It updates on every grant.

## Timing
- Reset values:
  - `arvalid=0`, `arid=0`, `araddr=0`, `arsize=0`, `rready=0`, `last_grant=1` (data), both counters 0.
  - `addr_ok`, `data_ok`, and `resp_err` are forced to 0 while `aresetn` is low.
- Asserting reset mid-operation (AR pending or reads outstanding) clears all state immediately. R beats for reads issued before reset are dropped.
- `addr_ok` is combinational in the grant cycle. `arvalid` rises on the following edge, so AR latency is 1 cycle from request to `arvalid`.
- Back-to-back grants: if `arready=1` every cycle, one AR per cycle is sustained.
- While `arvalid=1 && arready=0`: `arid`, `araddr`, and `arsize` are held stable and no `addr_ok` is given.
- `data_ok` is a 0-cycle path from `rvalid`.
- A counter at `MAX_OUTS` that decrements in cycle N allows a grant to that requester in cycle N+1.

## Configuration
- `AXI_RD_ARB_RR_EN` defined: round-robin.
  - When both requesters are eligible, the grant goes to the one not equal to `last_grant`.
  - After reset, inst wins the first tie.
- `AXI_RD_ARB_RR_EN` undefined: fixed priority, data over inst. `last_grant` is unused.

## Test plan
- Reset mid-AR: `inst_rd_req=1`, `addr=0x1c000000`, granted, `arready=0`, then `aresetn=0` for 1 cycle → `arvalid=0` asynchronously; after release `arvalid` stays 0 until a new grant.
- RR tie (macro defined): both reqs held 4 cycles, `arready=1` → grants inst, data, inst, data; `arid` sequence 0,1,0,1.
- Outstanding limit: `MAX_OUTS=2`, `inst_rd_req` held, no R → exactly 2 `inst_rd_addr_ok` pulses, then stall. Then `rvalid=1`, `rid=0`, `rlast=1` → third `addr_ok` in the next cycle.
- AR stall: `arready=0` for 3 cycles after grant of `data addr=0x800` with `size=2` → `araddr=0x800` and `arsize=3'd2` stay stable; no further `addr_ok` while both reqs are high.
- Routing/error: `rvalid=1`, `rid=1`, `rdata=0xDEADBEEF`, `rresp=2'b10` → `data_rd_data_ok=1`, `data_rd_rdata=0xDEADBEEF`, `inst_rd_data_ok=0`, `resp_err=1`. `rid=5` → no `data_ok`, counters unchanged.
- Fixed priority (macro undefined): both reqs held 3 cycles, `arready=1` → data granted all 3 cycles; inst granted only after `data_rd_req` drops.
